imu_spi_responder: RTL
======================

IMU_SPI_RESPONDER -- requirements
Module: imu_spi_responder

Interface
REQ-001 Parameter WHO_AM_I_VAL, default 8'h6C, value returned on reads of address 0x0F.
REQ-002 Parameter SYNC_STAGES, default 2, flip-flop stages on each of CS, SPC and SDI.
REQ-003 clk  input  1  system clock; all state is updated on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 CS  input  1  chip select, active-low, driven by the SPI initiator.
REQ-006 SPC  input  1  serial clock, SPI mode 3 (idle high).
REQ-007 SDI  input  1  serial data from the initiator, MSB first.
REQ-008 SDO  output  1  serial data to the initiator, MSB first.
REQ-009 accel_x, accel_y, accel_z  input  16 each  signed sample values to present on the bus.
REQ-010 ctrl1, ctrl2  output  8 each  writable control registers at 0x10 and 0x11.
REQ-011 wr_valid  output  1  one-cycle pulse for each completed write byte.
REQ-012 wr_addr  output  7  address of the completed write byte.
REQ-013 wr_data  output  8  data of the completed write byte.
REQ-014 frame_active  output  1  high while a frame is in progress.

Function
REQ-015 CS, SPC and SDI shall each pass through SYNC_STAGES flops; edges shall be detected on the synchronized signals only.
REQ-016 SPC high and low phases shall each last at least 4 clk periods; behaviour at faster SPC is undefined.
REQ-017 The FSM shall have four states: IDLE, ADDR, RD, WR.
REQ-018 On a synchronized CS falling edge, the FSM shall move IDLE->ADDR, clear the bit counter, and capture accel_x/y/z into a snapshot.
REQ-019 SDI shall be sampled on each synchronized SPC rising edge while CS is low, shifting into an 8-bit register MSB first.
REQ-020 After 8 ADDR bits: bit7=1 selects RD and bit7=0 selects WR; bits6:0 load the address pointer.
REQ-021 In RD, SDO shall present the MSB of the addressed byte on the first SPC falling edge after the 8th address bit, then shift one bit on each subsequent falling edge.
REQ-022 In RD, after each 8 bits the address pointer shall increment and the next byte shall be fetched before the following falling edge.
REQ-023 In WR, each completed byte shall pulse wr_valid for exactly 1 clk with wr_addr equal to the pointer and wr_data equal to the byte.
REQ-024 In WR, if the pointer is 0x10 or 0x11, ctrl1 or ctrl2 shall update on the same cycle as wr_valid; the pointer shall then increment.
REQ-025 The address pointer shall wrap from 0x7F to 0x00.
REQ-026 Read map:
- 0x0F -> WHO_AM_I_VAL
- 0x10/0x11 -> ctrl1/ctrl2
- 0x28..0x2D -> snapshot X_L, X_H, Y_L, Y_H, Z_L, Z_H (little-endian)
- all other addresses -> 8'h00
REQ-027 Writes to read-only or unmapped addresses shall pulse wr_valid but change no register.
REQ-028 A synchronized CS rising edge at any time shall return the FSM to IDLE and discard any partial byte (no wr_valid).
REQ-029 SDO shall be 1 whenever the FSM is not in RD.
REQ-030 frame_active shall be 1 in ADDR, RD and WR, and 0 in IDLE.
REQ-031 Snapshot values shall stay constant for the whole frame regardless of changes on accel_* inputs.

Reset
REQ-032 While rst_n is low:
- FSM in IDLE
- SDO=1, frame_active=0, wr_valid=0, wr_addr=0, wr_data=0
- ctrl1=0, ctrl2=0
- snapshot, bit counter and pointer all 0
- synchronizer flops preset to 1 (CS and SPC idle-high)
REQ-033 Reset asserted mid-frame shall abort the frame; after release the block shall ignore SPC until a new CS falling edge.

Verification
REQ-034 Read 0x8F, then 8 clocks -> SDO bytes 0x6C; frame_active high throughout; SDO=1 after CS rises.
REQ-035 Write 0x10, 0xA5, 0x3C -> wr_valid pulses (0x10,0xA5) and (0x11,0x3C); ctrl1=0xA5, ctrl2=0x3C; read-back 0x90 returns 0xA5, 0x3C.
REQ-036 accel_x=0x1234, accel_y=0xBEEF, accel_z=0x8001; start read 0xA8, change inputs mid-frame -> returns 34 12 EF BE 01 80.
REQ-037 Read 0xFF for 2 bytes -> bytes from 0x7F then 0x00, both 0x00 (confirms wrap).
REQ-038 Write 0x10, raise CS after 5 data bits -> no wr_valid; ctrl1 unchanged.
REQ-039 Assert rst_n low mid-read -> SDO=1, ctrl1=ctrl2=0; a new read of 0x8F after release returns 0x6C.

Source files
------------

// File: rtl/imu_spi_responder.sv
// SPI mode-3 target emulating a small IMU register file: WHO_AM_I, two control
// registers and a per-frame snapshot of the accelerometer samples.
module imu_spi_responder #(
   parameter logic [7:0]  WHO_AM_I_VAL = 8'h6C,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        CS,
   input  logic        SPC,
   input  logic        SDI,
   output logic        SDO,
   input  logic [15:0] accel_x,
   input  logic [15:0] accel_y,
   input  logic [15:0] accel_z,
   output logic [7:0]  ctrl1,
   output logic [7:0]  ctrl2,
   output logic        wr_valid,
   output logic [6:0]  wr_addr,
   output logic [7:0]  wr_data,
   output logic        frame_active
);

   typedef enum logic [1:0] {IDLE, ADDR, RD, WR} state_t;

   state_t state_q, state_d;

   // CS/SPC pipes carry one extra flop beyond the synchronizer to hold the previous value.
   logic [SYNC_STAGES:0]   cs_pipe_q, cs_pipe_d;
   logic [SYNC_STAGES:0]   spc_pipe_q, spc_pipe_d;
   logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;

   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic [6:0]  ptr_q, ptr_d;
   logic [7:0]  rd_sh_q, rd_sh_d;
   logic        sdo_q, sdo_d;
   logic [7:0]  ctrl1_q, ctrl1_d;
   logic [7:0]  ctrl2_q, ctrl2_d;
   logic        wr_valid_q, wr_valid_d;
   logic [6:0]  wr_addr_q, wr_addr_d;
   logic [7:0]  wr_data_q, wr_data_d;
   logic [15:0] snap_x_q, snap_x_d;
   logic [15:0] snap_y_q, snap_y_d;
   logic [15:0] snap_z_q, snap_z_d;

   logic       cs_s, cs_prev, spc_s, spc_prev, sdi_s;
   logic       cs_fall, cs_rise, spc_fall, spc_rise;
   logic [7:0] shift_in;
   logic [7:0] rd_byte;

   assign cs_s     = cs_pipe_q[SYNC_STAGES-1];
   assign cs_prev  = cs_pipe_q[SYNC_STAGES];
   assign spc_s    = spc_pipe_q[SYNC_STAGES-1];
   assign spc_prev = spc_pipe_q[SYNC_STAGES];
   assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];

   assign cs_fall  =  cs_prev  & ~cs_s;
   assign cs_rise  = ~cs_prev  &  cs_s;
   assign spc_fall =  spc_prev & ~spc_s;
   assign spc_rise = ~spc_prev &  spc_s;

   assign shift_in = {shift_q[6:0], sdi_s};

   always_comb begin
      rd_byte = 8'h00;
      case (ptr_q)
         7'h0F:   rd_byte = WHO_AM_I_VAL;
         7'h10:   rd_byte = ctrl1_q;
         7'h11:   rd_byte = ctrl2_q;
         7'h28:   rd_byte = snap_x_q[7:0];
         7'h29:   rd_byte = snap_x_q[15:8];
         7'h2A:   rd_byte = snap_y_q[7:0];
         7'h2B:   rd_byte = snap_y_q[15:8];
         7'h2C:   rd_byte = snap_z_q[7:0];
         7'h2D:   rd_byte = snap_z_q[15:8];
         default: rd_byte = 8'h00;
      endcase
   end

   always_comb begin
      cs_pipe_d  = {cs_pipe_q[SYNC_STAGES-1:0], CS};
      spc_pipe_d = {spc_pipe_q[SYNC_STAGES-1:0], SPC};
      sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], SDI};

      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      ptr_d      = ptr_q;
      rd_sh_d    = rd_sh_q;
      sdo_d      = sdo_q;
      ctrl1_d    = ctrl1_q;
      ctrl2_d    = ctrl2_q;
      wr_valid_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      snap_x_d   = snap_x_q;
      snap_y_d   = snap_y_q;
      snap_z_d   = snap_z_q;

      if (cs_rise) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (cs_fall) begin
                  state_d   = ADDR;
                  bit_cnt_d = '0;
                  snap_x_d  = accel_x;
                  snap_y_d  = accel_y;
                  snap_z_d  = accel_z;
               end
            end
            ADDR: begin
               sdo_d = 1'b1;
               if (spc_rise) begin
                  shift_d   = shift_in;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     ptr_d   = shift_in[6:0];
                     state_d = shift_in[7] ? RD : WR;
                  end
               end
            end
            RD: begin
               // The counter tracks falling edges here; bit 0 of each byte fetches from the pointer.
               if (spc_fall) begin
                  if (bit_cnt_q == 3'd0) begin
                     sdo_d   = rd_byte[7];
                     rd_sh_d = {rd_byte[6:0], 1'b0};
                  end else begin
                     sdo_d   = rd_sh_q[7];
                     rd_sh_d = {rd_sh_q[6:0], 1'b0};
                  end
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     ptr_d = ptr_q + 7'd1;
                  end
               end
            end
            WR: begin
               if (spc_rise) begin
                  shift_d   = shift_in;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     wr_valid_d = 1'b1;
                     wr_addr_d  = ptr_q;
                     wr_data_d  = shift_in;
                     if (ptr_q == 7'h10) begin
                        ctrl1_d = shift_in;
                     end else if (ptr_q == 7'h11) begin
                        ctrl2_d = shift_in;
                     end
                     ptr_d = ptr_q + 7'd1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cs_pipe_q  <= '1;
         spc_pipe_q <= '1;
         sdi_sync_q <= '1;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         ptr_q      <= '0;
         rd_sh_q    <= '0;
         sdo_q      <= 1'b1;
         ctrl1_q    <= '0;
         ctrl2_q    <= '0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         snap_x_q   <= '0;
         snap_y_q   <= '0;
         snap_z_q   <= '0;
      end else begin
         state_q    <= state_d;
         cs_pipe_q  <= cs_pipe_d;
         spc_pipe_q <= spc_pipe_d;
         sdi_sync_q <= sdi_sync_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         ptr_q      <= ptr_d;
         rd_sh_q    <= rd_sh_d;
         sdo_q      <= sdo_d;
         ctrl1_q    <= ctrl1_d;
         ctrl2_q    <= ctrl2_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         snap_x_q   <= snap_x_d;
         snap_y_q   <= snap_y_d;
         snap_z_q   <= snap_z_d;
      end
   end

   assign SDO          = (state_q == RD) ? sdo_q : 1'b1;
   assign frame_active = (state_q != IDLE);
   assign ctrl1        = ctrl1_q;
   assign ctrl2        = ctrl2_q;
   assign wr_valid     = wr_valid_q;
   assign wr_addr      = wr_addr_q;
   assign wr_data      = wr_data_q;

endmodule
